// File: rtl/reg_file_sb_pkg.sv
// Shared pipeline constants: datapath width, register count, address-width helper
// and the hardwired-zero register index. Also used by the decode and hazard units.
package reg_file_sb_pkg;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int REG0      = 0;

  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/popcount_nregs.sv
// Combinational population count of an NREGS-wide vector.
module popcount_nregs #(
  parameter int NREGS = 32,
  parameter int CW    = $clog2(NREGS) + 1
) (
  input  logic [NREGS-1:0] vec,
  output logic [CW-1:0]    cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + {{(CW-1){1'b0}}, vec[i]};
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with same-cycle write bypass and a per-register
// busy scoreboard; x0 is hardwired to zero and never busy.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRP   = 2,
  parameter int NWP   = 2,
  localparam int AW   = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                hazard,
  output logic [AW:0]         pending_cnt
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy, busy_nxt;
  logic [AW:0]                cnt_nxt;

  // Ascending port loop: the highest-indexed port lands last and wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int w = 0; w < NWP; w++)
        if (we[w] && waddr[w*AW +: AW] != AW'(REG0))
          regs[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
    end
  end

  // Clears first, then the issue set, so a same-cycle set/clear ends busy.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWP; w++)
      if (we[w]) busy_nxt[waddr[w*AW +: AW]] = 1'b0;
    if (iss_valid && iss_rd != AW'(REG0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[REG0] = 1'b0;
  end

  popcount_nregs #(.NREGS(NREGS), .CW(AW+1)) u_popcnt (
    .vec (busy_nxt),
    .cnt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            byp;

    assign ra = raddr[p*AW +: AW];

    always_comb begin
      d   = regs[ra];
      byp = 1'b0;
      for (int w = 0; w < NWP; w++)
        if (we[w] && waddr[w*AW +: AW] == ra && ra != AW'(REG0)) begin
          d   = wdata[w*XLEN +: XLEN];
          byp = 1'b1;
        end
    end

    assign rdata[p*XLEN +: XLEN] = d;
    assign rbusy[p]              = busy[ra] & ~byp;
  end

  assign hazard = |rbusy;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values are powers of two, at least 2.
REQ-003 SHALL have parameter NRP, default 2, number of read ports.
REQ-004 SHALL have parameter NWP, default 2, number of write ports.
REQ-005 SHALL use derived constant AW = log2(NREGS), the address width.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port raddr, input, NRP*AW, read addresses; port p occupies bits [p*AW +: AW].
REQ-009 SHALL have port rdata, output, NRP*XLEN, read data per port.
REQ-010 SHALL have port rbusy, output, NRP, scoreboard busy flag per read port, after bypass.
REQ-011 SHALL have port we, input, NWP, write enable per write port.
REQ-012 SHALL have port waddr, input, NWP*AW, write addresses.
REQ-013 SHALL have port wdata, input, NWP*XLEN, write data.
REQ-014 SHALL have port iss_valid, input, 1, issue request: mark register iss_rd pending.
REQ-015 SHALL have port iss_rd, input, AW, destination register of the issuing instruction.
REQ-016 SHALL have port hazard, output, 1, OR of rbusy across all read ports.
REQ-017 SHALL have port pending_cnt, output, AW+1, number of registers currently marked busy.

Function
REQ-018 SHALL write wdata[w] into register waddr[w] on each rising clk when we[w]=1 and waddr[w]!=0.
REQ-019 SHALL hold register 0 at zero permanently: writes are ignored, reads return 0, rbusy is 0.
REQ-020 SHALL, when two or more write ports target the same register in one cycle, store the data of the highest-indexed port.
REQ-021 SHALL produce rdata combinationally with zero-cycle latency.
REQ-022 SHALL make rdata equal the data being written in the current cycle when raddr[p] matches an enabled, nonzero waddr, using the highest-indexed matching port; otherwise rdata SHALL equal the stored value.
REQ-023 SHALL keep one busy bit per register; the bit for register 0 is constant 0.
REQ-024 SHALL set busy[iss_rd] on the rising clk when iss_valid=1 and iss_rd!=0.
REQ-025 SHALL clear busy[waddr[w]] on the rising clk for every enabled write port.
REQ-026 SHALL let the set win when a set and a clear hit the same register in the same cycle, so the bit ends at 1.
REQ-027 SHALL treat a repeated issue to an already-busy register as idempotent: the bit stays 1 and the count is unchanged.
REQ-028 SHALL drive rbusy[p] = busy[raddr[p]] AND NOT (same-cycle write to raddr[p]).
REQ-029 SHALL keep pending_cnt equal to the population count of the busy vector; it is registered and updates on the same edge as the busy bits.
REQ-030 SHALL count at most NREGS-1 in pending_cnt; there is no overflow or wrap case.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear all registers, all busy bits and pending_cnt to 0.
REQ-032 SHALL, consequently, hold rdata at 0 and rbusy and hazard at 0 during reset, apart from same-cycle write bypass.
REQ-033 SHALL ignore writes and issues presented while rst_n=0.
REQ-034 SHALL discard all pending marks when reset is asserted mid-operation; nothing is retained across reset.
REQ-035 SHALL become operational on the first rising clk after rst_n deasserts.

Structure
REQ-036 SHALL take XLEN, NREGS, the AW derivation and the register-0 index constant from the shared pipeline package; the same package serves the decode and hazard units.
REQ-037 SHALL split out one sub-module, popcount_nregs, a combinational population count of the busy vector parametrised by NREGS.
REQ-038 SHALL keep the storage array, bypass muxes and scoreboard in the top module.

Verification
REQ-039 SHALL cover basic write/read: write x5=0xA on port 0, next cycle read x5 on both ports -> rdata=0xA, rbusy=0.
REQ-040 SHALL cover bypass: in one cycle write x6=0x1234 on port 1 and read x6 -> rdata=0x1234 in that cycle.
REQ-041 SHALL cover write collision: port 0 writes x7=0x1 and port 1 writes x7=0x2 in one cycle -> x7 reads 0x2; any write to x0 -> x0 reads 0.
REQ-042 SHALL cover the scoreboard: issue x8 -> pending_cnt=1 and reading x8 gives rbusy=1, hazard=1; write x8 -> same-cycle rbusy=0, next cycle pending_cnt=0.
REQ-043 SHALL cover simultaneous set and clear: issue x9 while writing x9 -> busy[x9]=1 and pending_cnt increments to 1.
REQ-044 SHALL cover mid-operation reset: with x10=0x55 and x10 pending, pulse rst_n low between clock edges -> immediately rdata(x10)=0 and pending_cnt=0.
